// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: execute redirect, instruction-memory handshake and
// the fetch-to-decode handoff. Names carry the direction as seen by the
// fetch unit (master side).
interface fetch_unit_if #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32
);
    logic                E_jmp_sel_i;
    logic [PC_WIDTH-1:0] E_nPC_i;

    logic                imem_req_o;
    logic [PC_WIDTH-1:0] imem_addr_o;
    logic                imem_gnt_i;
    logic                imem_rvalid_i;
    logic [XLEN-1:0]     imem_rdata_i;

    logic                F_valid_o;
    logic [XLEN-1:0]     F_instr_o;
    logic [PC_WIDTH-1:0] F_PC_o;
    logic [PC_WIDTH-1:0] F_nPC_o;
    logic                D_ready_i;

    modport master (
        input  E_jmp_sel_i, E_nPC_i,
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output F_valid_o, F_instr_o, F_PC_o, F_nPC_o,
        input  D_ready_i
    );

    modport slave (
        output E_jmp_sel_i, E_nPC_i,
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  F_valid_o, F_instr_o, F_PC_o, F_nPC_o,
        output D_ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues at most one outstanding instruction-memory
// request, buffers returned words in a 2-entry {PC, instr} FIFO for decode,
// and handles execute redirects by flushing and squashing wrong-path data.
module fetch_unit #(
    parameter int                  XLEN     = 32,
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] tag_q, tag_d;
    logic [1:0]          count_q, count_d;
    logic [PC_WIDTH-1:0] fifoPc_q [2];
    logic [PC_WIDTH-1:0] fifoPc_d [2];
    logic [XLEN-1:0]     fifoInstr_q [2];
    logic [XLEN-1:0]     fifoInstr_d [2];

    logic                redirect;
    logic [PC_WIDTH-1:0] redirectPc;
    logic                issue;
    logic                granted;
    logic                headValid;
    logic                fetchValid;
    logic                push;
    logic                pop;

    assign redirect   = bus.E_jmp_sel_i;
    assign redirectPc = bus.E_nPC_i & ~PC_WIDTH'(3);
    assign issue      = (state_q == REQ) && (count_q < 2'd2);
    assign granted    = issue && bus.imem_gnt_i;
    assign headValid  = (count_q != 2'd0);
    assign fetchValid = headValid && !redirect;
    assign push       = (state_q == WAIT) && bus.imem_rvalid_i && !redirect;
    assign pop        = fetchValid && bus.D_ready_i;

    assign bus.imem_req_o  = issue;
    assign bus.imem_addr_o = pc_q;
    assign bus.F_valid_o   = fetchValid;
    assign bus.F_instr_o   = headValid ? fifoInstr_q[0] : '0;
    assign bus.F_PC_o      = headValid ? fifoPc_q[0] : '0;
    assign bus.F_nPC_o     = headValid ? (fifoPc_q[0] + PC_WIDTH'(4)) : '0;

    // Next-state for the request FSM, PC, issued-address tag and FIFO; redirect overrides all.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tag_d       = tag_q;
        count_d     = count_q;
        fifoPc_d    = fifoPc_q;
        fifoInstr_d = fifoInstr_q;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redirect) begin
                    state_d = granted ? DROP : REQ;
                end else if (granted) begin
                    state_d = WAIT;
                    tag_d   = pc_q;
                    pc_d    = pc_q + PC_WIDTH'(4);
                end
            end
            WAIT: begin
                if (bus.imem_rvalid_i) begin
                    state_d = REQ;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.imem_rvalid_i) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            pc_d    = redirectPc;
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        fifoPc_d[0]    = tag_q;
                        fifoInstr_d[0] = bus.imem_rdata_i;
                        count_d        = 2'd1;
                    end else if (count_q == 2'd1) begin
                        fifoPc_d[1]    = tag_q;
                        fifoInstr_d[1] = bus.imem_rdata_i;
                        count_d        = 2'd2;
                    end
                end
                2'b01: begin
                    fifoPc_d[0]    = fifoPc_q[1];
                    fifoInstr_d[0] = fifoInstr_q[1];
                    count_d        = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        fifoPc_d[0]    = tag_q;
                        fifoInstr_d[0] = bus.imem_rdata_i;
                    end else begin
                        fifoPc_d[0]    = fifoPc_q[1];
                        fifoInstr_d[0] = fifoInstr_q[1];
                        fifoPc_d[1]    = tag_q;
                        fifoInstr_d[1] = bus.imem_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers with asynchronous active-low reset back to the fetch start point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            tag_q          <= '0;
            count_q        <= 2'd0;
            fifoPc_q[0]    <= '0;
            fifoPc_q[1]    <= '0;
            fifoInstr_q[0] <= '0;
            fifoInstr_q[1] <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            tag_q          <= tag_d;
            count_q        <= count_d;
            fifoPc_q[0]    <= fifoPc_d[0];
            fifoPc_q[1]    <= fifoPc_d[1];
            fifoInstr_q[0] <= fifoInstr_d[0];
            fifoInstr_q[1] <= fifoInstr_d[1];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: in-order sequential fetch, backpressure,
// redirects in WAIT/REQ, PC wrap and reset during an outstanding request.
module tb_fetch_unit;

    logic        clock;
    logic        rst_n;
    int          checkCount;
    int          failCount;

    logic        holdResp;
    logic        badData;
    logic        pending;
    logic        grantedNow;
    logic [31:0] grantAddr;
    logic [31:0] pendingAddr;

    fetch_unit_if #(.XLEN(32), .PC_WIDTH(32)) bus ();

    fetch_unit #(.XLEN(32), .PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clock),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory grants every request in the cycle it is raised.
    assign bus.imem_gnt_i = bus.imem_req_o;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'h1300_0000 ^ addr;
    endfunction

    // Memory responder: answers a grant one cycle later unless held off.
    initial begin
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        pending           = 1'b0;
        pendingAddr       = '0;
        forever begin
            @(negedge clock);
            grantedNow = bus.imem_req_o & bus.imem_gnt_i;
            grantAddr  = bus.imem_addr_o;
            @(posedge clock);
            #1;
            if (grantedNow) begin
                pending     = 1'b1;
                pendingAddr = grantAddr;
            end
            if (pending && !holdResp) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = badData ? 32'hDEAD_BEEF : memWord(pendingAddr);
                pending           = 1'b0;
            end else begin
                bus.imem_rvalid_i = 1'b0;
                bus.imem_rdata_i  = '0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic jmp, input logic [31:0] target, input logic dReady);
        bus.E_jmp_sel_i = jmp;
        bus.E_nPC_i     = target;
        bus.D_ready_i   = dReady;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #3;
    endtask

    // Bound the whole run in case something stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence; comments name the cycle counted from reset release.
    initial begin
        checkCount = 0;
        failCount  = 0;
        holdResp   = 1'b0;
        badData    = 1'b0;
        rst_n      = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1);

        tick(2);
        checkOutput("rst_req",   {31'b0, bus.imem_req_o}, 32'h0);
        checkOutput("rst_valid", {31'b0, bus.F_valid_o}, 32'h0);
        checkOutput("rst_pc",    bus.F_PC_o, 32'h0);
        checkOutput("rst_npc",   bus.F_nPC_o, 32'h0);
        checkOutput("rst_instr", bus.F_instr_o, 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("c0_req_idle", {31'b0, bus.imem_req_o}, 32'h0);

        tick(1); // C1: first request at RESET_PC
        checkOutput("c1_req",  {31'b0, bus.imem_req_o}, 32'h1);
        checkOutput("c1_addr", bus.imem_addr_o, 32'h0);
        tick(1); // C2: waiting
        checkOutput("c2_req",   {31'b0, bus.imem_req_o}, 32'h0);
        checkOutput("c2_valid", {31'b0, bus.F_valid_o}, 32'h0);
        tick(1); // C3: first instruction
        checkOutput("c3_valid", {31'b0, bus.F_valid_o}, 32'h1);
        checkOutput("c3_pc",    bus.F_PC_o, 32'h0);
        checkOutput("c3_npc",   bus.F_nPC_o, 32'h4);
        checkOutput("c3_instr", bus.F_instr_o, 32'h1300_0000);
        checkOutput("c3_addr",  bus.imem_addr_o, 32'h4);
        tick(2); // C5
        checkOutput("c5_pc",   bus.F_PC_o, 32'h4);
        checkOutput("c5_addr", bus.imem_addr_o, 32'h8);
        tick(2); // C7
        checkOutput("c7_pc",   bus.F_PC_o, 32'h8);
        checkOutput("c7_npc",  bus.F_nPC_o, 32'hC);
        checkOutput("c7_addr", bus.imem_addr_o, 32'hC);
        applyStimulus(1'b0, 32'h0, 1'b0);

        tick(2); // C9: FIFO full, requests stop
        checkOutput("c9_req", {31'b0, bus.imem_req_o}, 32'h0);
        checkOutput("c9_pc",  bus.F_PC_o, 32'h8);
        tick(3); // C12
        checkOutput("c12_req",   {31'b0, bus.imem_req_o}, 32'h0);
        checkOutput("c12_valid", {31'b0, bus.F_valid_o}, 32'h1);
        checkOutput("c12_pc",    bus.F_PC_o, 32'h8);
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick(1); // C13: one pop, one new request
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("c13_pc",   bus.F_PC_o, 32'hC);
        checkOutput("c13_req",  {31'b0, bus.imem_req_o}, 32'h1);
        checkOutput("c13_addr", bus.imem_addr_o, 32'h10);
        tick(2); // C15: full again
        checkOutput("c15_req", {31'b0, bus.imem_req_o}, 32'h0);
        checkOutput("c15_pc",  bus.F_PC_o, 32'hC);

        applyStimulus(1'b1, 32'h200, 1'b0);
        #1;
        checkOutput("redir_full_valid", {31'b0, bus.F_valid_o}, 32'h0);
        tick(1); // C16: flushed, new address
        applyStimulus(1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("c16_valid", {31'b0, bus.F_valid_o}, 32'h0);
        checkOutput("c16_req",   {31'b0, bus.imem_req_o}, 32'h1);
        checkOutput("c16_addr",  bus.imem_addr_o, 32'h200);
        tick(2); // C18
        checkOutput("c18_valid", {31'b0, bus.F_valid_o}, 32'h1);
        checkOutput("c18_pc",    bus.F_PC_o, 32'h200);
        checkOutput("c18_instr", bus.F_instr_o, 32'h1300_0200);
        applyStimulus(1'b0, 32'h0, 1'b1);

        tick(2); // C20
        checkOutput("c20_pc",   bus.F_PC_o, 32'h204);
        checkOutput("c20_addr", bus.imem_addr_o, 32'h208);
        holdResp = 1'b1;
        tick(1); // C21: WAIT, response held off
        checkOutput("c21_req",   {31'b0, bus.imem_req_o}, 32'h0);
        checkOutput("c21_valid", {31'b0, bus.F_valid_o}, 32'h0);
        applyStimulus(1'b1, 32'h103, 1'b1);
        tick(1); // C22: DROP
        applyStimulus(1'b0, 32'h0, 1'b1);
        holdResp = 1'b0;
        badData  = 1'b1;
        #1;
        checkOutput("c22_req", {31'b0, bus.imem_req_o}, 32'h0);
        tick(1); // C23: wrong-path response on the bus
        checkOutput("c23_valid", {31'b0, bus.F_valid_o}, 32'h0);
        checkOutput("c23_req",   {31'b0, bus.imem_req_o}, 32'h0);
        checkOutput("c23_instr", bus.F_instr_o, 32'h0);
        tick(1); // C24
        checkOutput("c24_req",   {31'b0, bus.imem_req_o}, 32'h1);
        checkOutput("c24_addr",  bus.imem_addr_o, 32'h100);
        checkOutput("c24_valid", {31'b0, bus.F_valid_o}, 32'h0);
        badData = 1'b0;
        tick(2); // C26
        checkOutput("c26_pc",    bus.F_PC_o, 32'h100);
        checkOutput("c26_instr", bus.F_instr_o, 32'h1300_0100);
        checkOutput("c26_addr",  bus.imem_addr_o, 32'h104);

        applyStimulus(1'b1, 32'h300, 1'b1);
        #1;
        checkOutput("redir_gnt_valid", {31'b0, bus.F_valid_o}, 32'h0);
        tick(1); // C27: DROP
        applyStimulus(1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("c27_req",   {31'b0, bus.imem_req_o}, 32'h0);
        checkOutput("c27_valid", {31'b0, bus.F_valid_o}, 32'h0);
        tick(1); // C28
        checkOutput("c28_req",  {31'b0, bus.imem_req_o}, 32'h1);
        checkOutput("c28_addr", bus.imem_addr_o, 32'h300);
        tick(2); // C30
        checkOutput("c30_pc",    bus.F_PC_o, 32'h300);
        checkOutput("c30_instr", bus.F_instr_o, 32'h1300_0300);

        applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b1);
        tick(1); // C31: DROP
        applyStimulus(1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("c31_req", {31'b0, bus.imem_req_o}, 32'h0);
        tick(1); // C32
        checkOutput("c32_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
        tick(2); // C34: wrapped
        checkOutput("c34_pc",    bus.F_PC_o, 32'hFFFF_FFFC);
        checkOutput("c34_npc",   bus.F_nPC_o, 32'h0);
        checkOutput("c34_instr", bus.F_instr_o, 32'hECFF_FFFC);
        checkOutput("c34_addr",  bus.imem_addr_o, 32'h0);
        checkOutput("c34_req",   {31'b0, bus.imem_req_o}, 32'h1);
        holdResp = 1'b1;

        tick(1); // C35: reset while a request is outstanding
        rst_n = 1'b0;
        #1;
        checkOutput("wrst_req",   {31'b0, bus.imem_req_o}, 32'h0);
        checkOutput("wrst_valid", {31'b0, bus.F_valid_o}, 32'h0);
        checkOutput("wrst_pc",    bus.F_PC_o, 32'h0);
        checkOutput("wrst_instr", bus.F_instr_o, 32'h0);
        tick(1); // C36: release, stale response follows
        rst_n    = 1'b1;
        holdResp = 1'b0;
        #1;
        checkOutput("c36_req", {31'b0, bus.imem_req_o}, 32'h0);
        tick(1); // C37
        checkOutput("c37_req",   {31'b0, bus.imem_req_o}, 32'h1);
        checkOutput("c37_addr",  bus.imem_addr_o, 32'h0);
        checkOutput("c37_valid", {31'b0, bus.F_valid_o}, 32'h0);
        tick(1); // C38
        checkOutput("c38_valid", {31'b0, bus.F_valid_o}, 32'h0);
        tick(1); // C39
        checkOutput("c39_valid", {31'b0, bus.F_valid_o}, 32'h1);
        checkOutput("c39_pc",    bus.F_PC_o, 32'h0);
        checkOutput("c39_instr", bus.F_instr_o, 32'h1300_0000);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
